mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single-port memory between instruction fetch and the execute stage's load/store accesses.
- Grants one requester at a time and drives the memory port.
- Counts a fixed memory latency, then returns read data to the granted requester.
- Data accesses have priority; a starvation guard keeps fetch making progress.
- A fetch flush (taken branch/JALR) cancels an in-flight fetch response.

Parameters:
XLEN, 32, data/address width
MEM_LAT, 2, cycles from mem_en to mem_rdata valid (>=1)
STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  XLEN  fetch address
if_flush  in  1  discard in-flight fetch response
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  XLEN  fetch data
d_req  in  1  data request; held until d_gnt
d_we  in  1  1=store, 0=load
d_be  in  4  byte enables (store)
d_addr  in  XLEN  data address
d_wdata  in  XLEN  store data
d_gnt  out  1  data accepted this cycle
d_rvalid  out  1  load data / store ack (1-cycle pulse)
d_rdata  out  XLEN  load data; 0 for stores
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_be  out  4  memory byte enables
mem_addr  out  XLEN  memory address
mem_wdata  out  XLEN  memory write data
mem_rdata  in  XLEN  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- States:
  - IDLE: no access outstanding.
  - BUSY: access outstanding; owner register src = IF or D; latency counter cnt.
- Grant is combinational in IDLE only.
  - Winner is D if d_req, unless starve_cnt == STARVE_MAX and if_req, in which case IF wins.
  - Otherwise IF wins if if_req.
  - In the grant cycle: winner's gnt = 1; mem_en = 1; mem_we = d_we for D, 0 for IF; mem_be = d_be for D, 4'hF for IF; mem_addr/mem_wdata from winner (wdata 0 for IF).
  - Next state is BUSY, cnt = 0.
- BUSY:
  - No grants; mem_en = 0. cnt increments each cycle.
  - In cycle grant+MEM_LAT: capture mem_rdata into the owner's rdata register (0 for a store). The owner's rvalid is registered high the following cycle, i.e. grant+MEM_LAT+1.
  - State returns to IDLE in that same cycle, so the earliest next grant is grant+MEM_LAT+1. Throughput is one access per MEM_LAT+1 cycles.
- rvalid pulses for exactly one cycle. rdata holds its value until the next response to that requester.
- starve_cnt (clog2(STARVE_MAX+1) bits):
  - +1 on each D grant while if_req = 1, saturating at STARVE_MAX.
  - Cleared on an IF grant or in any cycle with if_req = 0.
- if_flush:
  - Asserted in any cycle while src = IF in BUSY, including the grant cycle: sets a drop flag, and the fetch response is not signalled (if_rvalid stays 0; if_rdata is not updated). The flag clears on return to IDLE.
  - Asserted in IDLE: no effect on arbitration. Fetch retracts or changes if_req/if_addr itself.
  - Never affects a D transaction.
- Simultaneous d_req and if_req with starve_cnt < STARVE_MAX: D wins; IF waits.
- Requesters may not drop or change req/addr before gnt. Arbiter behaviour under such changes is unspecified.
- Reset (any state, including mid-transaction):
  - Next cycle: state IDLE; cnt, starve_cnt, drop flag = 0.
  - All gnt/rvalid/mem_* outputs = 0; if_rdata/d_rdata = 0.
  - In-flight response discarded.
- Address alignment is not checked; d_be passes through unchanged.

Decomposition:
- Shared package fewcore_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_BUSY}
  - constants ARB_SRC_IF = 1'b0, ARB_SRC_D = 1'b1
  - MEM_BE_ALL = 4'hF
- Single module; no sub-module (counter and grant logic are inline).

Test Plan:
- Lone fetch (MEM_LAT = 2): if_req, if_addr = 0x100 at t0 -> if_gnt, mem_en, mem_addr = 0x100 at t0; mem_rdata = 0x00000013 at t2 -> if_rvalid = 1, if_rdata = 0x00000013 at t3; next grant possible at t3.
- Contention: if_req and d_req (load 0x2000) both high at t0 -> d_gnt at t0, if_gnt at t3, d_rvalid at t3, if_rvalid at t6.
- Starvation (STARVE_MAX = 4): d_req held continuously with if_req high -> four D grants, then the 5th grant goes to IF; starve_cnt returns to 0.
- Store: d_we = 1, d_be = 4'b0011, d_addr = 0x40, d_wdata = 0xDEADBEEF -> mem_we = 1, mem_be = 4'b0011, mem_wdata = 0xDEADBEEF at grant; d_rvalid pulse with d_rdata = 0 at grant+3.
- Flush: fetch granted at t0, if_flush at t1 -> no if_rvalid at t3, if_rdata unchanged; a new if_req at t3 is granted at t3.
- Reset mid-BUSY: reset at grant+1 -> all outputs 0 the next cycle; no rvalid ever appears for the dropped access; a request after reset deasserts is granted normally.

Source files
------------

// File: rtl/fewcore_pkg.sv
// Shared definitions for the fewcore memory-port arbiter.
package fewcore_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic       ARB_SRC_IF = 1'b0;
    localparam logic       ARB_SRC_D  = 1'b1;
    localparam logic [3:0] MEM_BE_ALL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between instruction fetch and load/store.
// Data requests win unless fetch has been passed over STARVE_MAX times in a
// row. One access is outstanding at a time; the response is returned
// MEM_LAT+1 cycles after the grant as a one-cycle rvalid pulse.
module mem_port_arbiter
    import fewcore_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    // The latency counter only has to reach MEM_LAT-1; the starvation counter
    // has to hold STARVE_MAX itself.
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned SW    = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(MEM_LAT - 1);
    localparam logic [SW-1:0]    STARVE_LIMIT = SW'(STARVE_MAX);

    arb_state_t      state_q, state_d;
    logic            src_q, src_d;
    logic            we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            drop_q, drop_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            grant_if, grant_d;

    // Grant selection, memory port drive, latency counting and response capture.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        drop_d      = drop_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_if    = 1'b0;
        grant_d     = 1'b0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_be      = 4'h0;
        mem_addr    = '0;
        mem_wdata   = '0;

        if (!reset && state_q == ARB_IDLE) begin
            if (d_req && !(starve_q == STARVE_LIMIT && if_req)) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end

        if (grant_d) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            state_d   = ARB_BUSY;
            src_d     = ARB_SRC_D;
            we_d      = d_we;
            cnt_d     = '0;
            drop_d    = 1'b0;
        end else if (grant_if) begin
            if_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_be    = MEM_BE_ALL;
            mem_addr  = if_addr;
            state_d   = ARB_BUSY;
            src_d     = ARB_SRC_IF;
            we_d      = 1'b0;
            cnt_d     = '0;
            drop_d    = if_flush;
        end

        if (state_q == ARB_BUSY) begin
            cnt_d = cnt_q + 1'b1;
            if (src_q == ARB_SRC_IF && if_flush) begin
                drop_d = 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
                drop_d  = 1'b0;
                if (src_q == ARB_SRC_D) begin
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = we_q ? '0 : mem_rdata;
                end else if (!(drop_q || if_flush)) begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = mem_rdata;
                end
            end
        end

        if (!if_req || grant_if) begin
            starve_d = '0;
        end else if (grant_d && starve_q != STARVE_LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // State and response registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            src_q       <= ARB_SRC_IF;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            starve_q    <= '0;
            drop_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            drop_q      <= drop_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for fetch, store and
// contention, plus hand-written starvation, flush and reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifReq, ifFlush, dReq, dWe;
    logic [31:0] ifAddr, dAddr, dWdata, memRdata;
    logic [3:0]  dBe;
    logic        ifGnt, ifRvalid, dGnt, dRvalid, memEn, memWe;
    logic [31:0] ifRdata, dRdata, memAddr, memWdata;
    logic [3:0]  memBe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        ifFlush;
        logic        dReq;
        logic        dWe;
        logic [3:0]  dBe;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic [31:0] memRdata;
    } stim_t;

    typedef struct {
        logic        ifGnt;
        logic        ifRvalid;
        logic [31:0] ifRdata;
        logic        dGnt;
        logic        dRvalid;
        logic [31:0] dRdata;
        logic        memEn;
        logic        memWe;
        logic [3:0]  memBe;
        logic [31:0] memAddr;
        logic [31:0] memWdata;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t vecs[16];

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (ifReq),
        .if_addr   (ifAddr),
        .if_flush  (ifFlush),
        .if_gnt    (ifGnt),
        .if_rvalid (ifRvalid),
        .if_rdata  (ifRdata),
        .d_req     (dReq),
        .d_we      (dWe),
        .d_be      (dBe),
        .d_addr    (dAddr),
        .d_wdata   (dWdata),
        .d_gnt     (dGnt),
        .d_rvalid  (dRvalid),
        .d_rdata   (dRdata),
        .mem_en    (memEn),
        .mem_we    (memWe),
        .mem_be    (memBe),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .mem_rdata (memRdata)
    );

    always #5 clk = ~clk;

    // Hard stop in case a sequence never completes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        reset    = s.rst;
        ifReq    = s.ifReq;
        ifAddr   = s.ifAddr;
        ifFlush  = s.ifFlush;
        dReq     = s.dReq;
        dWe      = s.dWe;
        dBe      = s.dBe;
        dAddr    = s.dAddr;
        dWdata   = s.dWdata;
        memRdata = s.memRdata;
    endtask

    task automatic clearInputs();
        reset = 0; ifReq = 0; ifAddr = 0; ifFlush = 0; dReq = 0; dWe = 0;
        dBe = 0; dAddr = 0; dWdata = 0; memRdata = 0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRow(input int r, input exp_t e);
        string p;
        p = $sformatf("row%0d.", r);
        checkOutput({p, "ifGnt"},    ifGnt,    e.ifGnt);
        checkOutput({p, "ifRvalid"}, ifRvalid, e.ifRvalid);
        checkOutput({p, "ifRdata"},  ifRdata,  e.ifRdata);
        checkOutput({p, "dGnt"},     dGnt,     e.dGnt);
        checkOutput({p, "dRvalid"},  dRvalid,  e.dRvalid);
        checkOutput({p, "dRdata"},   dRdata,   e.dRdata);
        checkOutput({p, "memEn"},    memEn,    e.memEn);
        checkOutput({p, "memWe"},    memWe,    e.memWe);
        checkOutput({p, "memBe"},    memBe,    e.memBe);
        checkOutput({p, "memAddr"},  memAddr,  e.memAddr);
        checkOutput({p, "memWdata"}, memWdata, e.memWdata);
    endtask

    initial begin
        int idx;
        // stim: rst ifReq ifAddr ifFlush dReq dWe dBe dAddr dWdata memRdata
        // exp : ifGnt ifRvalid ifRdata dGnt dRvalid dRdata memEn memWe memBe memAddr memWdata
        vecs[0]  = '{'{0,0,0,0,0,0,0,0,0,0},
                     '{0,0,0,0,0,0,0,0,0,0,0}};
        vecs[1]  = '{'{0,1,32'h100,0,0,0,0,0,0,0},
                     '{1,0,0,0,0,0,1,0,4'hF,32'h100,0}};
        vecs[2]  = '{'{0,0,0,0,0,0,0,0,0,32'h11111111},
                     '{0,0,0,0,0,0,0,0,0,0,0}};
        vecs[3]  = '{'{0,0,0,0,0,0,0,0,0,32'h00000013},
                     '{0,0,0,0,0,0,0,0,0,0,0}};
        vecs[4]  = '{'{0,0,0,0,1,1,4'b0011,32'h40,32'hDEADBEEF,32'h22222222},
                     '{0,1,32'h13,1,0,0,1,1,4'b0011,32'h40,32'hDEADBEEF}};
        vecs[5]  = '{'{0,0,0,0,0,0,0,0,0,32'h33333333},
                     '{0,0,32'h13,0,0,0,0,0,0,0,0}};
        vecs[6]  = '{'{0,0,0,0,0,0,0,0,0,32'h44444444},
                     '{0,0,32'h13,0,0,0,0,0,0,0,0}};
        vecs[7]  = '{'{0,0,0,0,0,0,0,0,0,0},
                     '{0,0,32'h13,0,1,0,0,0,0,0,0}};
        vecs[8]  = '{'{0,1,32'h104,0,1,0,4'hF,32'h2000,0,0},
                     '{0,0,32'h13,1,0,0,1,0,4'hF,32'h2000,0}};
        vecs[9]  = '{'{0,1,32'h104,0,0,0,0,0,0,32'h66666666},
                     '{0,0,32'h13,0,0,0,0,0,0,0,0}};
        vecs[10] = '{'{0,1,32'h104,0,0,0,0,0,0,32'hCAFE0001},
                     '{0,0,32'h13,0,0,0,0,0,0,0,0}};
        vecs[11] = '{'{0,1,32'h104,0,0,0,0,0,0,32'h55555555},
                     '{1,0,32'h13,0,1,32'hCAFE0001,1,0,4'hF,32'h104,0}};
        vecs[12] = '{'{0,0,0,0,0,0,0,0,0,0},
                     '{0,0,32'h13,0,0,32'hCAFE0001,0,0,0,0,0}};
        vecs[13] = '{'{0,0,0,0,0,0,0,0,0,32'h00000093},
                     '{0,0,32'h13,0,0,32'hCAFE0001,0,0,0,0,0}};
        vecs[14] = '{'{0,0,0,0,0,0,0,0,0,32'h77777777},
                     '{0,1,32'h93,0,0,32'hCAFE0001,0,0,0,0,0}};
        vecs[15] = '{'{0,0,0,0,0,0,0,0,0,0},
                     '{0,0,32'h93,0,0,32'hCAFE0001,0,0,0,0,0}};

        clearInputs();
        reset = 1;
        @(posedge clk);
        @(posedge clk);

        // Lone fetch, store, then contention between a load and a fetch.
        for (int r = 0; r < 16; r++) begin
            nextCycle();
            applyStimulus(vecs[r].s);
            @(negedge clk);
            checkRow(r, vecs[r].e);
        end

        // Starvation: both sides request continuously; every fifth grant is fetch.
        idx = 0;
        for (int t = 0; t < 40; t++) begin
            nextCycle();
            ifReq = 1; ifAddr = 32'h200;
            dReq = 1; dWe = 0; dBe = 4'hF; dAddr = 32'h3000;
            memRdata = 32'h0000ABCD;
            @(negedge clk);
            if (dGnt || ifGnt) begin
                checkOutput($sformatf("starveWho%0d", idx), ifGnt, (idx % 5) == 4);
                checkOutput($sformatf("starveCycle%0d", idx), t, idx * 3);
                idx++;
                if (idx == 10) break;
            end
        end
        checkOutput("starveGrants", idx, 10);
        for (int t = 0; t < 4; t++) begin
            nextCycle();
            clearInputs();
            memRdata = 32'h0000ABCD;
        end
        @(negedge clk);
        checkOutput("starveIfRdata", ifRdata, 32'h0000ABCD);

        // Flush one cycle after a fetch grant suppresses that response.
        nextCycle();
        clearInputs(); ifReq = 1; ifAddr = 32'h300;
        @(negedge clk);
        checkOutput("flushGnt", ifGnt, 1);
        nextCycle();
        clearInputs(); ifFlush = 1;
        nextCycle();
        clearInputs(); memRdata = 32'h77777777;
        nextCycle();
        clearInputs(); ifReq = 1; ifAddr = 32'h304;
        @(negedge clk);
        checkOutput("flushNoRvalid", ifRvalid, 0);
        checkOutput("flushRdataHeld", ifRdata, 32'h0000ABCD);
        checkOutput("flushRegrant", ifGnt, 1);
        checkOutput("flushRegrantAddr", memAddr, 32'h304);
        nextCycle();
        clearInputs();
        nextCycle();
        clearInputs(); memRdata = 32'h00000099;
        nextCycle();
        clearInputs();
        @(negedge clk);
        checkOutput("postFlushRvalid", ifRvalid, 1);
        checkOutput("postFlushRdata", ifRdata, 32'h00000099);

        // Reset one cycle after a load grant abandons the load.
        nextCycle();
        clearInputs(); dReq = 1; dBe = 4'hF; dAddr = 32'h500;
        @(negedge clk);
        checkOutput("rstLoadGnt", dGnt, 1);
        nextCycle();
        clearInputs(); reset = 1; memRdata = 32'h5555AAAA;
        nextCycle();
        clearInputs(); memRdata = 32'h5555AAAA;
        @(negedge clk);
        checkOutput("rstIfRdata", ifRdata, 0);
        checkOutput("rstDRdata", dRdata, 0);
        checkOutput("rstMemEn", memEn, 0);
        checkOutput("rstGnt", {dGnt, ifGnt}, 0);
        checkOutput("rstRvalid", {dRvalid, ifRvalid}, 0);
        for (int t = 0; t < 3; t++) begin
            nextCycle();
            clearInputs(); memRdata = 32'h5555AAAA;
            @(negedge clk);
            checkOutput($sformatf("rstNoRvalid%0d", t), dRvalid, 0);
        end
        nextCycle();
        clearInputs(); dReq = 1; dBe = 4'hF; dAddr = 32'h504;
        @(negedge clk);
        checkOutput("rstRegrant", dGnt, 1);
        checkOutput("rstRegrantAddr", memAddr, 32'h504);
        nextCycle();
        clearInputs();
        nextCycle();
        clearInputs(); memRdata = 32'h00001234;
        nextCycle();
        clearInputs();
        @(negedge clk);
        checkOutput("rstNewRvalid", dRvalid, 1);
        checkOutput("rstNewRdata", dRdata, 32'h00001234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
